// File: rtl/tpu_job_sequencer.sv
// Job-level controller for the systolic TPU top: streams operands into its serial
// load port, pulses init, waits for the serial result, buffers it and emits words.
module tpu_job_sequencer #(
   parameter int D_W      = 8,
   parameter int N        = 2,
   parameter int COMP_LAT = 4,
   parameter int TIMEOUT  = 255
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             clear_err,
   output logic             busy,
   output logic             done,
   output logic             err,
   input  logic             src_bit_x,
   input  logic             src_bit_y,
   input  logic             src_valid,
   output logic             src_ready,
   output logic             load_en,
   output logic             data_in_x,
   output logic             data_in_y,
   output logic             init,
   input  logic             tx_ready,
   input  logic             data_out_z,
   output logic [2*D_W-1:0] res_word,
   output logic             res_valid,
   input  logic             res_ready,
   output logic             res_last
);

   localparam int LOAD_BITS = N * N * D_W;
   localparam int RES_WORDS = N * N;
   localparam int WORD_W    = 2 * D_W;
   localparam int LCNT_W    = $clog2(LOAD_BITS + 1);
   localparam int BIT_W     = $clog2(WORD_W);
   localparam int PTR_W     = (RES_WORDS > 1) ? $clog2(RES_WORDS) : 1;

   typedef enum logic [2:0] {
      IDLE, LOAD, INIT, COMPUTE, WAIT_TX, DRAIN, EMIT, DONE
   } state_t;

   state_t            state, state_nxt;
   logic [LCNT_W-1:0] load_cnt;
   logic [7:0]        wait_cnt;
   logic [BIT_W-1:0]  word_bit;
   logic [PTR_W-1:0]  wr_ptr, rd_ptr, rd_nxt;
   logic [WORD_W-1:0] res_buf [RES_WORDS];
   logic [WORD_W-1:0] shifted;
   logic              src_hs, res_hs, capture, err_event;

   always_comb begin
      state_nxt = state;
      err_event = 1'b0;
      src_hs    = (state == LOAD) && src_valid && src_ready;
      res_hs    = (state == EMIT) && res_valid && res_ready;
      capture   = (state == DRAIN) || ((state == WAIT_TX) && tx_ready);
      rd_nxt    = res_hs ? rd_ptr + 1'b1 : rd_ptr;
      shifted   = {res_buf[wr_ptr][WORD_W-2:0], data_out_z};
      case (state)
         IDLE:    if (start) state_nxt = LOAD;
         LOAD:    if (src_hs && load_cnt == LCNT_W'(LOAD_BITS - 1)) state_nxt = INIT;
         INIT:    state_nxt = COMPUTE;
         COMPUTE: if (wait_cnt == 8'(COMP_LAT - 1)) state_nxt = WAIT_TX;
         WAIT_TX: begin
            if (tx_ready) begin
               state_nxt = DRAIN;
            end else if (wait_cnt == 8'(TIMEOUT - 1)) begin
               state_nxt = IDLE;
               err_event = 1'b1;
            end
         end
         DRAIN: begin
            // The drain runs by bit count; a dropped tx_ready is only flagged.
            if (!tx_ready) err_event = 1'b1;
            if (wr_ptr == PTR_W'(RES_WORDS - 1) && word_bit == BIT_W'(WORD_W - 1))
               state_nxt = EMIT;
         end
         EMIT:    if (res_hs && rd_ptr == PTR_W'(RES_WORDS - 1)) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         load_cnt  <= '0;
         wait_cnt  <= '0;
         word_bit  <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         src_ready <= 1'b0;
         load_en   <= 1'b0;
         data_in_x <= 1'b0;
         data_in_y <= 1'b0;
         init      <= 1'b0;
         res_word  <= '0;
         res_valid <= 1'b0;
         res_last  <= 1'b0;
         for (int i = 0; i < RES_WORDS; i++) res_buf[i] <= '0;
      end else begin
         state     <= state_nxt;
         busy      <= (state_nxt != IDLE);
         done      <= (state_nxt == DONE);
         src_ready <= (state_nxt == LOAD);
         init      <= (state == INIT);
         load_en   <= src_hs;
         if (src_hs) begin
            data_in_x <= src_bit_x;
            data_in_y <= src_bit_y;
         end

         if (state != LOAD)    load_cnt <= '0;
         else if (src_hs)      load_cnt <= load_cnt + 1'b1;

         if (state_nxt != state)                          wait_cnt <= '0;
         else if (state == COMPUTE || state == WAIT_TX)   wait_cnt <= wait_cnt + 1'b1;

         // Result bits arrive MSB-first, so each word is built by shifting left.
         if (capture) begin
            res_buf[wr_ptr] <= shifted;
            if (word_bit == BIT_W'(WORD_W - 1)) begin
               word_bit <= '0;
               wr_ptr   <= wr_ptr + 1'b1;
            end else begin
               word_bit <= word_bit + 1'b1;
            end
         end else begin
            word_bit <= '0;
            wr_ptr   <= '0;
         end

         if (state_nxt == EMIT) begin
            rd_ptr    <= rd_nxt;
            res_valid <= 1'b1;
            res_last  <= (rd_nxt == PTR_W'(RES_WORDS - 1));
            res_word  <= (capture && wr_ptr == rd_nxt) ? shifted : res_buf[rd_nxt];
         end else begin
            rd_ptr    <= '0;
            res_valid <= 1'b0;
            res_last  <= 1'b0;
            res_word  <= '0;
         end

         if (err_event)       err <= 1'b1;
         else if (clear_err)  err <= 1'b0;
      end
   end

endmodule

// File: tb/tb_tpu_job_sequencer.sv
// Directed bench for tpu_job_sequencer: the bench plays both the operand source
// and the TPU top's serial result stream, with hand-computed expectations.
module tb_tpu_job_sequencer;

   localparam int D_W       = 8;
   localparam int N         = 2;
   localparam int COMP_LAT  = 4;
   localparam int TIMEOUT   = 255;
   localparam int LOAD_BITS = N * N * D_W;
   localparam int RES_WORDS = N * N;
   localparam int RES_BITS  = RES_WORDS * 2 * D_W;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic            start = 1'b0;
   logic            clear_err = 1'b0;
   logic            busy, done, err;
   logic            src_bit_x = 1'b0;
   logic            src_bit_y = 1'b0;
   logic            src_valid = 1'b0;
   logic            src_ready;
   logic            load_en, data_in_x, data_in_y, init;
   logic            tx_ready = 1'b0;
   logic            data_out_z = 1'b0;
   logic [2*D_W-1:0] res_word;
   logic            res_valid;
   logic            res_ready = 1'b0;
   logic            res_last;

   logic [31:0] x_pat   = 32'hA5C3_0F96;
   logic [31:0] y_pat   = 32'h3C5A_F00D;
   logic [63:0] res_pat = 64'h0102_0304_0506_0708;
   logic [15:0] exp_words [RES_WORDS] = '{16'h0102, 16'h0304, 16'h0506, 16'h0708};

   int checks = 0;
   int errors = 0;

   tpu_job_sequencer #(.D_W(D_W), .N(N), .COMP_LAT(COMP_LAT), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst), .start(start), .clear_err(clear_err),
      .busy(busy), .done(done), .err(err),
      .src_bit_x(src_bit_x), .src_bit_y(src_bit_y), .src_valid(src_valid), .src_ready(src_ready),
      .load_en(load_en), .data_in_x(data_in_x), .data_in_y(data_in_y), .init(init),
      .tx_ready(tx_ready), .data_out_z(data_out_z),
      .res_word(res_word), .res_valid(res_valid), .res_ready(res_ready), .res_last(res_last)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Pulses start and feeds LOAD_BITS operand pairs; returns on the cycle init is seen.
   task automatic loadOperands(input bit toggle);
      bit hs_prev = 1'b0;
      bit prev_load = 1'b0;
      bit init_seen = 1'b0;
      int r = 0, s = 0, ready_cycles = 0;
      start = 1'b1;
      step();
      start = 1'b0;
      checkOutput("busy_after_start", busy, 1);
      for (int i = 0; i < 300; i++) begin
         checkOutput("load_en", load_en, hs_prev);
         if (hs_prev) begin
            checkOutput("data_in_x", data_in_x, x_pat[r]);
            checkOutput("data_in_y", data_in_y, y_pat[r]);
            r++;
         end
         if (init) begin
            init_seen = 1'b1;
            checkOutput("init_after_last_load", prev_load, 1);
            checkOutput("load_count", r, LOAD_BITS);
            checkOutput("ready_cycles", ready_cycles, toggle ? 2 * LOAD_BITS : LOAD_BITS);
            checkOutput("src_ready_dropped", src_ready, 0);
            break;
         end
         prev_load = load_en;
         src_valid = toggle ? (i % 2 == 1) : 1'b1;
         src_bit_x = (s < LOAD_BITS) ? x_pat[s] : 1'b0;
         src_bit_y = (s < LOAD_BITS) ? y_pat[s] : 1'b0;
         hs_prev   = src_valid && src_ready;
         if (src_ready) ready_cycles++;
         if (hs_prev) s++;
         step();
      end
      src_valid = 1'b0;
      if (!init_seen) checkOutput("init_seen", 0, 1);
   endtask

   // Plays the TPU result stream; drop_at >= 0 drops tx_ready for one bit while clear_err is high.
   task automatic streamResult(input int tx_delay, input int drop_at);
      for (int i = 0; i < tx_delay + RES_BITS; i++) begin
         if (i == 1) checkOutput("init_one_cycle", init, 0);
         tx_ready   = (i >= tx_delay) && (i != tx_delay + drop_at);
         clear_err  = (i == tx_delay + drop_at);
         data_out_z = (i >= tx_delay) ? res_pat[RES_BITS - 1 - (i - tx_delay)] : 1'b0;
         step();
      end
      tx_ready   = 1'b0;
      clear_err  = 1'b0;
      data_out_z = 1'b0;
   endtask

   // Accepts words with res_ready held low for stall cycles per word, then checks done.
   task automatic collectResult(input int stall);
      int k = 0, held = 0, i = 0;
      while (k < RES_WORDS && i < 200) begin
         res_ready = (held >= stall);
         if (res_valid) begin
            checkOutput("res_word", res_word, exp_words[k]);
            checkOutput("res_last", res_last, (k == RES_WORDS - 1));
            checkOutput("no_early_done", done, 0);
            if (res_ready) begin
               k++;
               held = 0;
            end else begin
               held++;
            end
         end
         i++;
         step();
      end
      res_ready = 1'b0;
      checkOutput("words_emitted", k, RES_WORDS);
      checkOutput("emit_cycles", i, RES_WORDS * (stall + 1));
      checkOutput("done_pulse", done, 1);
      checkOutput("valid_after_last", res_valid, 0);
      step();
      checkOutput("done_one_cycle", done, 0);
      checkOutput("busy_back_idle", busy, 0);
   endtask

   task automatic applyStimulus(input bit toggle, input int tx_delay, input int drop_at, input int stall);
      loadOperands(toggle);
      streamResult(tx_delay, drop_at);
      collectResult(stall);
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput(tag, {busy, done, err, src_ready, load_en, data_in_x, data_in_y,
                        init, res_valid, res_last, res_word}, 0);
   endtask

   initial begin
      int i;
      step();
      step();
      checkAllZero("reset_outputs");
      rst = 1'b1;
      step();
      checkOutput("idle_not_busy", busy, 0);

      $display("[TB] job with continuous operand stream, res_ready high");
      applyStimulus(1'b0, COMP_LAT, -1, 0);
      checkOutput("no_err_clean_job", err, 0);

      $display("[TB] job with toggling src_valid, stalled consumer, tx_ready glitch");
      applyStimulus(1'b1, COMP_LAT + 2, 10, 5);
      checkOutput("drain_drop_err_wins", err, 1);
      clear_err = 1'b1;
      step();
      clear_err = 1'b0;
      checkOutput("err_cleared", err, 0);

      $display("[TB] job with tx_ready never asserted");
      loadOperands(1'b0);
      i = 0;
      while (busy && i < 400) begin
         if (i == COMP_LAT + TIMEOUT - 1) checkOutput("err_before_timeout", err, 0);
         step();
         i++;
      end
      checkOutput("timeout_cycles", i, COMP_LAT + TIMEOUT);
      checkOutput("timeout_err", err, 1);
      checkOutput("timeout_no_done", done, 0);
      step();
      checkOutput("err_sticky", err, 1);
      clear_err = 1'b1;
      step();
      clear_err = 1'b0;
      checkOutput("timeout_err_cleared", err, 0);
      applyStimulus(1'b0, COMP_LAT + 1, -1, 0);

      $display("[TB] reset asserted during drain");
      loadOperands(1'b0);
      for (int j = 0; j < COMP_LAT + 20; j++) begin
         tx_ready   = (j >= COMP_LAT);
         data_out_z = (j >= COMP_LAT) ? res_pat[RES_BITS - 1 - (j - COMP_LAT)] : 1'b0;
         step();
      end
      checkOutput("busy_in_drain", busy, 1);
      rst = 1'b0;
      #1;
      checkAllZero("async_reset_outputs");
      tx_ready   = 1'b0;
      data_out_z = 1'b0;
      step();
      rst = 1'b1;
      step();
      checkAllZero("after_reset_release");
      applyStimulus(1'b0, COMP_LAT, -1, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
